// File: rtl/div_const_pkg.sv
// Shared constants, state encoding and digit/remainder types for the
// sequential constant divider and its per-digit step.
package div_const_pkg;

    localparam int unsigned DIVISOR = 23;
    localparam int unsigned REM_W   = $clog2(DIVISOR);
    localparam int unsigned CHUNK   = 4;
    localparam int unsigned STEP_W  = REM_W + CHUNK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef logic [REM_W-1:0] rem_t;
    typedef logic [CHUNK-1:0] digit_t;

endpackage

// File: rtl/div23_step.sv
// One radix-2^CHUNK long-division step: {rem_in, chunk} / DIVISOR as a
// restoring compare/subtract chain against shifted copies of the constant.
module div23_step
    import div_const_pkg::*;
(
    input  rem_t   rem_in,
    input  digit_t chunk,
    output digit_t q,
    output rem_t   rem_out
);

    logic [STEP_W-1:0] w_v;

    always_comb begin
        w_v = {rem_in, chunk};
        q   = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (w_v >= STEP_W'(DIVISOR << i)) begin
                w_v  = w_v - STEP_W'(DIVISOR << i);
                q[i] = 1'b1;
            end
        end
        rem_out = rem_t'(w_v);
    end

endmodule

// File: rtl/div23_seq64.sv
// Sequential divide-by-constant: retires one CHUNK-bit dividend digit per
// cycle, MSB first, with valid/ready handshakes on input and output.
module div23_seq64
    import div_const_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output rem_t             out_remainder
);

    localparam int unsigned N_ITER = WIDTH / CHUNK;
    localparam int unsigned ITER_W = $clog2(N_ITER);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic [WIDTH-1:0]  r_dvd;
    logic [WIDTH-1:0]  r_quo;
    rem_t              r_rem;
    logic [ITER_W-1:0] r_iter;
    logic [WIDTH-1:0]  r_out_q;
    rem_t              r_out_r;

    digit_t            w_q;
    rem_t              w_rem;
    logic              w_accept;
    logic              w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == BUSY) && (r_iter == LAST_ITER);

    div23_step u_step (
        .rem_in  (r_rem),
        .chunk   (r_dvd[WIDTH-1 -: CHUNK]),
        .q       (w_q),
        .rem_out (w_rem)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = BUSY;
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Shift registers, iteration counter and result holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_iter  <= '0;
            r_out_q <= '0;
            r_out_r <= '0;
        end else if (w_accept) begin
            r_dvd  <= in_dividend;
            r_quo  <= '0;
            r_rem  <= '0;
            r_iter <= '0;
        end else if (r_state == BUSY) begin
            r_dvd  <= r_dvd << CHUNK;
            r_quo  <= {r_quo[WIDTH-CHUNK-1:0], w_q};
            r_rem  <= w_rem;
            r_iter <= r_iter + ITER_W'(1);
            if (w_last) begin
                r_out_q <= {r_quo[WIDTH-CHUNK-1:0], w_q};
                r_out_r <= w_rem;
            end
        end
    end

    assign out_quotient  = r_out_q;
    assign out_remainder = r_out_r;

endmodule
